// File: rtl/trisc_pkg.sv
// Shared types and constants for the TRISC RAM arbiter: RAM geometry, port
// ownership and the RAM command bundle.
package trisc_pkg;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 8;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_LDR = 1'b1
   } owner_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic              wren;
   } ram_cmd_t;

   localparam ram_cmd_t RAM_CMD_IDLE = '{addr: {ADDR_W{1'b0}}, wdata: {DATA_W{1'b0}}, wren: 1'b0};

endpackage

// File: rtl/ld_addr_ptr.sv
// Front-panel loader address pointer: clear wins over increment, and the
// counter wraps naturally at the top of the address space.
module ld_addr_ptr #(
   parameter int ADDR_W = 4
) (
   input  logic              i_clk,
   input  logic              i_clr,
   input  logic              i_addr_clr,
   input  logic              i_inc,
   output logic [ADDR_W-1:0] o_addr
);

   logic [ADDR_W-1:0] r_addr;

   // Pointer register: system reset, loader clear, then post-access increment.
   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_addr <= {ADDR_W{1'b0}};
      end else if (i_addr_clr) begin
         r_addr <= {ADDR_W{1'b0}};
      end else if (i_inc) begin
         r_addr <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
         r_addr <= r_addr;
      end
   end

   assign o_addr = r_addr;

endmodule

// File: rtl/trisc_ram_arbiter.sv
// Arbitrates the single-port TRISC RAM between the processor datapath and the
// front-panel loader: round-robin in run mode, loader-only in load mode.
module trisc_ram_arbiter #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              SysClock,
   input  logic              Clear,
   input  logic              Mode,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [DATA_W-1:0] ld_wdata,
   input  logic              ld_addr_clr,
   output logic              ld_gnt,
   output logic              ld_rvalid,
   output logic [DATA_W-1:0] ld_rdata,
   output logic [ADDR_W-1:0] ld_addr,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_wren,
   input  logic [DATA_W-1:0] ram_q
);

   import trisc_pkg::*;

   owner_t            r_last_owner;
   logic              r_cpu_rvalid;
   logic              r_ld_rvalid;
   logic              w_cpu_gnt;
   logic              w_ld_gnt;
   logic [ADDR_W-1:0] w_ld_addr;
   ram_cmd_t          w_cmd;

   ld_addr_ptr #(
      .ADDR_W (ADDR_W)
   ) u_ld_addr_ptr (
      .i_clk      (SysClock),
      .i_clr      (Clear),
      .i_addr_clr (ld_addr_clr),
      .i_inc      (w_ld_gnt),
      .o_addr     (w_ld_addr)
   );

   // Grant decision; on a run-mode conflict the port that did not own the last access wins.
   always_comb begin
      w_cpu_gnt = 1'b0;
      w_ld_gnt  = 1'b0;
      if (Clear) begin
         w_cpu_gnt = 1'b0;
         w_ld_gnt  = 1'b0;
      end else if (Mode) begin
         w_ld_gnt  = ld_req;
      end else if (cpu_req && ld_req) begin
         w_cpu_gnt = (r_last_owner == OWN_LDR);
         w_ld_gnt  = (r_last_owner == OWN_CPU);
      end else begin
         w_cpu_gnt = cpu_req;
         w_ld_gnt  = ld_req;
      end
   end

   // RAM command mux; an idle cycle drives an all-zero command.
   always_comb begin
      w_cmd = RAM_CMD_IDLE;
      case ({w_cpu_gnt, w_ld_gnt})
         2'b10: w_cmd = '{addr: cpu_addr, wdata: cpu_wdata, wren: cpu_we};
         2'b01: w_cmd = '{addr: w_ld_addr, wdata: ld_wdata, wren: ld_we};
         default: w_cmd = RAM_CMD_IDLE;
      endcase
   end

   // Last owner resets to the loader so the CPU wins the first conflict.
   always_ff @(posedge SysClock) begin
      if (Clear) begin
         r_last_owner <= OWN_LDR;
      end else if (w_cpu_gnt) begin
         r_last_owner <= OWN_CPU;
      end else if (w_ld_gnt) begin
         r_last_owner <= OWN_LDR;
      end else begin
         r_last_owner <= r_last_owner;
      end
   end

   // Read-return flags follow the port that was granted, independent of later mode changes.
   always_ff @(posedge SysClock) begin
      if (Clear) begin
         r_cpu_rvalid <= 1'b0;
         r_ld_rvalid  <= 1'b0;
      end else begin
         r_cpu_rvalid <= w_cpu_gnt & ~cpu_we;
         r_ld_rvalid  <= w_ld_gnt & ~ld_we;
      end
   end

   // A Clear arriving while a read is returning cancels that return immediately.
   assign cpu_rvalid = r_cpu_rvalid & ~Clear;
   assign ld_rvalid  = r_ld_rvalid & ~Clear;
   assign cpu_rdata  = ram_q;
   assign ld_rdata   = ram_q;
   assign cpu_gnt    = w_cpu_gnt;
   assign ld_gnt     = w_ld_gnt;
   assign cpu_stall  = cpu_req & ~w_cpu_gnt;
   assign ld_addr    = w_ld_addr;
   assign ram_addr   = w_cmd.addr;
   assign ram_wdata  = w_cmd.wdata;
   assign ram_wren   = w_cmd.wren;

endmodule

// File: doc/trisc_ram_arbiter.md
# trisc_ram_arbiter

Shares the single-port 16×8 TRISC program/data RAM between the processor datapath (fetch, operand read, STORE write) and the front-panel loader port. The loader port writes or reads through an internal auto-incrementing address pointer. Arbitration is round-robin in run mode; the loader owns the RAM exclusively in load mode. The block sits between the control unit/accumulator path and the RAM, replacing the ad-hoc Mode muxes on address, data, write-enable and clock.

## Interface
Parameters:
- ADDR_W, 4, RAM address width (16 words)
- DATA_W, 8, RAM word width (opcode[7:4] | operand[3:0])

Ports:
- SysClock  in  1  single system clock; all state updates on rising edge
- Clear  in  1  synchronous, active-high reset
- Mode  in  1  0 = run (round-robin), 1 = load (loader only)
- cpu_req  in  1  processor access request, held until granted
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  processor address (PC or operand)
- cpu_wdata  in  DATA_W  processor write data
- cpu_gnt  out  1  access accepted this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rvalid  out  1  cpu_rdata valid (one cycle after a granted read)
- cpu_rdata  out  DATA_W  read data
- ld_req, ld_we  in  1  loader request and write select
- ld_wdata  in  DATA_W  loader write data
- ld_addr_clr  in  1  reset loader pointer to 0
- ld_gnt, ld_rvalid  out  1  as for CPU port
- ld_rdata  out  DATA_W  loader read data
- ld_addr  out  ADDR_W  current loader pointer (drives MAR display)
- ram_addr  out  ADDR_W; ram_wdata  out  DATA_W; ram_wren  out  1  RAM command
- ram_q  in  DATA_W  RAM read data; 1-cycle latency; RAM clocked by SysClock

## Operation
- Grant is combinational from requests and registered state. At most one grant per cycle. The RAM command is driven in the grant cycle.
- Mode=1: ld_gnt = ld_req; cpu_gnt = 0.
- Mode=0, single requester: that requester is granted.
- Mode=0, both requesting: grant goes to the port not recorded in last_owner. last_owner updates on every grant.
- Idle (no grant): ram_wren=0, ram_addr=0, ram_wdata=0.
- Loader accesses use ld_addr as the address. After every ld_gnt the pointer increments by 1 and wraps 15→0.
- ld_addr_clr has priority over increment. If clear and grant occur together, the access uses the old pointer and the pointer becomes 0.
- Read return: x_rvalid is registered, set one cycle after a granted read (x_we=0). x_rdata = ram_q, meaningful only while x_rvalid=1.
- Writes produce no rvalid.
- A Mode change takes effect in the same cycle for grants. An rvalid already in flight is still delivered to its original owner.

## Timing
- Reset values (Clear=1 at an edge):
  - cpu_rvalid=0, ld_rvalid=0
  - ld_addr=0
  - last_owner=LDR, so the CPU wins the first conflict
- While Clear=1: cpu_gnt=ld_gnt=0 and ram_wren=0, regardless of requests.
- Clear asserted mid-access: a pending rvalid is cancelled (0 on the next cycle). Write data already presented with ram_wren in a prior cycle is committed.
- Throughput: one access per cycle. Back-to-back grants to the same port are allowed when it is the sole requester.
- Under continuous contention the ports alternate, C,L,C,L…
- Latency: grant → RAM write at the same edge; grant → rvalid +1 cycle.
- Read-after-write to the same address on consecutive cycles returns the new data; the RAM is configured write-first.

## Structure
- Package trisc_pkg holds:
  - ADDR_W and DATA_W constants
  - owner_t enum {OWN_CPU, OWN_LDR}
  - RAM command struct (addr, wdata, wren)
- Sub-module ld_addr_ptr: loader pointer counter with clear-priority, increment-enable and wrap.
- Grant logic, command mux, last_owner and rvalid registers stay in the top.

## Test plan
- Reset: Clear=1 for 2 cycles with both requests high → no grants, ram_wren=0, ld_addr=0, rvalids 0.
- Load mode: Mode=1, 16 loader writes of 0x10..0x1F, then 17 reads → ld_addr wraps 15→0 and the 17th read returns 0x10. A cpu_req held throughout keeps cpu_stall=1.
- Contention: Mode=0, both requesting reads continuously → first grant goes to CPU, then strict alternation. Each rvalid arrives 1 cycle later on the correct port.
- Pointer clear collision: ld_addr=5, ld_req and ld_addr_clr in the same cycle → access to address 5, then ld_addr=0.
- Mode switch mid-read: CPU read granted at cycle t, Mode→1 at t+1 → cpu_rvalid still asserts at t+1 and CPU gets no further grants.
- Clear mid-read: granted read at t, Clear at t+1 → no rvalid at t+1; the next access after reset is granted to the CPU on conflict.
